// File: rtl/b_port_seq_pkg.sv
// Shared types and constants for the module_b port sequencer.
// Data widths come from the config.vh macros, not from this package.
package b_port_seq_pkg;

  localparam int unsigned RESP_LATENCY_MAX = 16;
  localparam int unsigned SettleCntW       = $clog2(RESP_LATENCY_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StResp
  } b_port_seq_state_t;

endpackage

// File: rtl/b_port_seq_fifo.sv
// Synchronous request FIFO. Read and write pointers carry an extra wrap bit
// so that full and empty can be told apart when the index bits match.
module b_port_seq_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_en, pop_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop_en)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/b_port_sequencer.sv
// Queues request words, drives each into module_b, waits a settle window and returns
// the sampled result on a valid/ready channel. Optional counter: B_PORT_SEQ_STATS_EN.
`ifndef DATA_FROM_A_BITWIDTH
`define DATA_FROM_A_BITWIDTH 8
`endif
`ifndef DATA_TO_A_BITWIDTH
`define DATA_TO_A_BITWIDTH 8
`endif

module b_port_sequencer
  import b_port_seq_pkg::*;
#(
  parameter int unsigned DATA_FROM_A_BITWIDTH = `DATA_FROM_A_BITWIDTH,
  parameter int unsigned DATA_TO_A_BITWIDTH   = `DATA_TO_A_BITWIDTH,
  parameter int unsigned RESP_LATENCY         = 2,
  parameter int unsigned REQ_FIFO_DEPTH       = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [DATA_FROM_A_BITWIDTH-1:0] req_data,
  output logic [DATA_FROM_A_BITWIDTH-1:0] data_from_a,
  input  logic [DATA_TO_A_BITWIDTH-1:0]   data_to_a,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_TO_A_BITWIDTH-1:0]   rsp_data,
  output logic [15:0]                     txn_count
);

  b_port_seq_state_t state_q, state_d;

  logic [SettleCntW-1:0]           cnt_q, cnt_d;
  logic [DATA_FROM_A_BITWIDTH-1:0] data_from_a_q, data_from_a_d;
  logic [DATA_TO_A_BITWIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                            rsp_valid_q, rsp_valid_d;

  logic                            fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [DATA_FROM_A_BITWIDTH-1:0] fifo_head;
  logic                            rsp_hs;

  assign req_ready = ~fifo_full;
  assign fifo_push = req_valid & req_ready;
  assign rsp_hs    = rsp_valid_q & rsp_ready;

  b_port_seq_fifo #(
    .Width (DATA_FROM_A_BITWIDTH),
    .Depth (REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .wdata_i (req_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_from_a_d = data_from_a_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = rsp_valid_q;
    fifo_pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          data_from_a_d = fifo_head;
          cnt_d         = SettleCntW'(RESP_LATENCY - 1);
          state_d       = StDrive;
        end
      end
      StDrive: begin
        // Counter reaching zero marks the last settle cycle: sample module_b now.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SettleCntW'(1);
        end else begin
          rsp_data_d  = data_to_a;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      data_from_a_q <= '0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      data_from_a_q <= data_from_a_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
    end
  end

  assign data_from_a = data_from_a_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_valid   = rsp_valid_q;

`ifdef B_PORT_SEQ_STATS_EN
  logic [15:0] txn_count_q, txn_count_d;

  always_comb begin
    txn_count_d = txn_count_q;
    if (rsp_hs) txn_count_d = txn_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) txn_count_q <= '0;
    else        txn_count_q <= txn_count_d;
  end

  assign txn_count = txn_count_q;
`else
  assign txn_count = '0;
`endif

endmodule

// File: doc/b_port_sequencer.md
# b_port_sequencer

Request/response sequencer placed directly upstream of `module_b`. It queues request words from the producer side, drives each onto `module_b`'s `data_from_a` input, holds it for a fixed settle window, then captures `module_b`'s `data_to_a` output and returns it on a valid/ready response channel. It provides the timed, one-at-a-time stimulus that `module_b`'s unclocked port pair needs.

## Interface
- `DATA_FROM_A_BITWIDTH`, default `` `DATA_FROM_A_BITWIDTH `` (config.vh): request / `data_from_a` width.
- `DATA_TO_A_BITWIDTH`, default `` `DATA_TO_A_BITWIDTH `` (config.vh): `data_to_a` / response width.
- `RESP_LATENCY`, default 2: cycles `data_from_a` is held before `data_to_a` is sampled. Legal range 1..16.
- `REQ_FIFO_DEPTH`, default 4: request queue depth. Must be a power of 2 and ≥2.
- `clk`  input  1: single clock, rising edge.
- `rst_n`  input  1: synchronous, active-low reset.
- `req_valid`  input  1: request word present.
- `req_ready`  output  1: queue can accept a word.
- `req_data`  input  DATA_FROM_A_BITWIDTH: request word.
- `data_from_a`  output  DATA_FROM_A_BITWIDTH: registered drive into `module_b`.
- `data_to_a`  input  DATA_TO_A_BITWIDTH: result from `module_b`.
- `rsp_valid`  output  1: captured result valid.
- `rsp_ready`  input  1: consumer accepts result.
- `rsp_data`  output  DATA_TO_A_BITWIDTH: captured result.
- `txn_count`  output  16: completed-transaction counter (see Configuration).

## Operation
- Request queue: push on `req_valid & req_ready`. `req_ready = !full`, combinational from occupancy only. No dependence on `req_valid`.
- Push and pop in the same cycle: both occur and occupancy is unchanged. Push while full is impossible because ready is low. Pop happens only when the queue is non-empty.
- FSM states are IDLE, DRIVE and RESP.
- IDLE, queue non-empty:
  - Pop the head and load it into `data_from_a`.
  - Load the settle counter with `RESP_LATENCY-1`.
  - Go to DRIVE.
- IDLE, queue empty: stay in IDLE. `data_from_a` holds its last value.
- DRIVE, counter ≠ 0: decrement.
- DRIVE, counter = 0: capture `data_to_a` into `rsp_data`, set `rsp_valid`, go to RESP.
- RESP:
  - Hold `rsp_valid` and `rsp_data` stable until `rsp_valid & rsp_ready`.
  - On handshake, clear `rsp_valid` and go to IDLE.
  - `data_from_a` is unchanged throughout RESP.
- Only one transaction is in flight. Requests keep queuing during DRIVE and RESP.
- Reset values: `data_from_a`=0, `rsp_valid`=0, `rsp_data`=0, `txn_count`=0, queue empty, state IDLE. After reset `req_ready`=1.
- Reset mid-transaction discards the queued words and the pending response. No partial response is emitted.

## Timing
- Request pushed at edge t: pop in cycle t+1. `data_from_a` shows the new word from cycle t+2.
- `data_to_a` is sampled at the end of cycle t+1+RESP_LATENCY.
- `rsp_valid` is first high in cycle t+2+RESP_LATENCY.
- Handshake in cycle r: state is IDLE in r+1, and the next pop can happen in r+1.
- Sustained throughput: one transaction per RESP_LATENCY+2 cycles when `rsp_ready` is held at 1.
- `module_b` is combinational between `data_from_a` and `data_to_a`. RESP_LATENCY covers its path depth.

## Configuration
- `B_PORT_SEQ_STATS_EN` defined:
  - `txn_count` increments by 1 on each response handshake and wraps from 0xFFFF to 0.
  - Synchronous reset clears it to 0.
- Not defined: `txn_count` is tied to 0 and no counter flop is synthesized. The port list is identical in both builds.

## Structure
- Package `b_port_seq_pkg`:
  - state enum `b_port_seq_state_t` (IDLE, DRIVE, RESP);
  - `RESP_LATENCY_MAX`=16;
  - settle counter width `$clog2(RESP_LATENCY_MAX)`.
- Data widths stay sourced from config.vh macros, not the package.
- One sub-module: `b_port_seq_fifo`.
  - Synchronous FIFO, parameterised width and depth.
  - Outputs full/empty, plus a pointer with an extra wrap bit.
- The FSM and capture register live in the top.

## Test plan
Test values use widths 8/8, RESP_LATENCY=2, REQ_FIFO_DEPTH=4. The `data_to_a` model returns `data_from_a` XOR 0xFF.
- Single request: push 0x3C at edge t. `data_from_a`=0x3C from t+2, `rsp_valid` at t+4 with `rsp_data`=0xC3. With the macro defined, `txn_count`=1 after the handshake.
- Backpressure: `rsp_ready`=0 for 10 cycles. `rsp_valid` and `rsp_data` stay stable and `data_from_a` is unchanged. Handshake on release, then IDLE the next cycle.
- Queue full: push 5 words with `rsp_ready`=0. `req_ready` drops after the 4th accepted push, or the 5th if a pop already occurred. No word is lost or duplicated, and responses return in order.
- Simultaneous push/pop: push on the same edge as an IDLE pop with occupancy 1. Occupancy stays 1 and order is preserved.
- Reset mid-operation: assert `rst_n`=0 during DRIVE with 3 words queued. Next cycle all outputs are at reset values, `req_ready`=1, and no response appears after release.
- Counter wrap with `B_PORT_SEQ_STATS_EN`: preload or run 65536 handshakes, `txn_count` returns to 0. Without the macro, `txn_count` is always 0.
